// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the MIPS-subset pipeline.
// Captures register operands, immediate, specifiers and decoded control for EX,
// detects load-use hazards (stall + bubble), squashes on branch flush and keeps
// a saturating bubble counter for performance debug.
// Optional feature: define WB_BYPASS_EN to forward same-cycle writeback data
// into the captured operands when the writeback register matches rs/rt.

module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Control byte layout: {regWrite, memToReg, memRead, memWrite, aluSrc, regDst, aluOp[1:0]}
  localparam int unsigned CTRL_MEMREAD = 5;
  localparam int unsigned CTRL_REGDST  = 2;

  // EX-slot state
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q,    ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,    ex_rt_d;
  logic [REG_AW-1:0] ex_dst_q,   ex_dst_d;
  logic [DATA_W-1:0] ex_a_q,     ex_a_d;
  logic [DATA_W-1:0] ex_b_q,     ex_b_d;
  logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
  logic [7:0]        ex_ctrl_q,  ex_ctrl_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              hazard_c;
  logic              bubble_c;
  logic              rs_match_c;
  logic              rt_match_c;
  logic [DATA_W-1:0] opnd_a_c;
  logic [DATA_W-1:0] opnd_b_c;

  // Load-use detection against the load currently sitting in EX ($0 never hazards)
  always_comb begin
    rs_match_c = (ex_rt_q == id_rs);
    rt_match_c = id_uses_rt && (ex_rt_q == id_rt);
    hazard_c   = id_valid && ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] &&
                 (ex_rt_q != REG_AW'(0)) && (rs_match_c || rt_match_c);
  end

  // Flush outranks the stall so a squashed slot never holds fetch
  assign stall = hazard_c && !flush;

  // Either flush or stall injects exactly one bubble this edge
  assign bubble_c = flush || hazard_c;

`ifdef WB_BYPASS_EN
  // Forward the value being written back this cycle over the stale regfile read
  always_comb begin
    opnd_a_c = id_rdata1;
    opnd_b_c = id_rdata2;
    if (wb_we && (wb_reg != REG_AW'(0)) && (wb_reg == id_rs)) begin
      opnd_a_c = wb_data;
    end
    if (wb_we && (wb_reg != REG_AW'(0)) && (wb_reg == id_rt)) begin
      opnd_b_c = wb_data;
    end
  end
`else
  // Operands come straight from the register file; writeback port is unused here
  logic wb_unused_c;
  assign wb_unused_c = wb_we ^ (^wb_reg) ^ (^wb_data);

  always_comb begin
    opnd_a_c = id_rdata1;
    opnd_b_c = id_rdata2;
  end
`endif

  // Next-state selection: flush > stall > capture > idle
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_dst_d   = ex_dst_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_ctrl_d  = ex_ctrl_q;
    cnt_d      = cnt_q;

    if (bubble_c) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 8'h00;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (id_valid) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_imm_d   = id_imm;
      ex_dst_d   = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
      ex_a_d     = opnd_a_c;
      ex_b_d     = opnd_b_c;
    end else begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 8'h00;
    end
  end

  // EX-slot register with asynchronous clear
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ex_valid_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dst_q   <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_ctrl_q  <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_dst_q   <= ex_dst_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_ctrl_q  <= ex_ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_dst     = ex_dst_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: table of stateful vectors plus
// hand-written reset-mid-stall and counter-saturation sequences.

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        init_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic [7:0]  id_ctrl;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .init_n(init_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    string       name;
    logic        vld;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] r1, r2, imm;
    logic [7:0]  ctrl;
    logic        fl;
    logic        wwe;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rs, e_rt, e_dst;
    logic [31:0] e_a, e_b, e_imm;
    logic [7:0]  e_ctrl;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP_A = 32'h0000ABCD;
`else
  localparam logic [31:0] BYP_A = 32'h00000000;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] dst,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [7:0] ctrl,
                          input logic [15:0] cnt);
    check({tag, ".ex_valid"}, 64'(ex_valid), 64'(v));
    check({tag, ".ex_rs"}, 64'(ex_rs), 64'(rs));
    check({tag, ".ex_rt"}, 64'(ex_rt), 64'(rt));
    check({tag, ".ex_dst"}, 64'(ex_dst), 64'(dst));
    check({tag, ".ex_a"}, 64'(ex_a), 64'(a));
    check({tag, ".ex_b"}, 64'(ex_b), 64'(b));
    check({tag, ".ex_imm"}, 64'(ex_imm), 64'(imm));
    check({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(ctrl));
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(cnt));
  endtask

  task automatic drive(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic uses_rt, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [7:0] ctrl,
                       input logic fl);
    id_valid = vld; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt;
    id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_ctrl = ctrl; flush = fl;
  endtask

  function automatic vec_t mk(input string name, input logic vld, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic uses_rt,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic [7:0] ctrl, input logic fl,
                              input logic e_stall, input logic e_valid,
                              input logic [4:0] e_rs, input logic [4:0] e_rt,
                              input logic [4:0] e_dst, input logic [31:0] e_a,
                              input logic [31:0] e_b, input logic [31:0] e_imm,
                              input logic [7:0] e_ctrl, input logic [15:0] e_cnt);
    vec_t v;
    v.name = name; v.vld = vld; v.rs = rs; v.rt = rt; v.rd = rd; v.uses_rt = uses_rt;
    v.r1 = r1; v.r2 = r2; v.imm = imm; v.ctrl = ctrl; v.fl = fl;
    v.wwe = 1'b0; v.wreg = 5'd0; v.wdata = 32'h0;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_rs = e_rs; v.e_rt = e_rt;
    v.e_dst = e_dst; v.e_a = e_a; v.e_b = e_b; v.e_imm = e_imm;
    v.e_ctrl = e_ctrl; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    vec_t v;
    init_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
    wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;

    // Stateful sequence: each row applies inputs, checks stall before the edge, outputs after
    //          name      vld rs rt rd  urt r1     r2       imm           ctrl  fl   stall vld rs rt dst a      b        imm           ctrl  cnt
    vecs.push_back(mk("capture", 1, 2, 3, 4, 1, 32'h11, 32'h22, 32'hFFFFFFF0, 8'h84, 0, 0, 1, 2, 3, 4, 32'h11, 32'h22, 32'hFFFFFFF0, 8'h84, 0));
    vecs.push_back(mk("lw_r5", 1, 1, 5, 0, 0, 32'h100, 32'h55, 32'h4, 8'hE8, 0, 0, 1, 1, 5, 5, 32'h100, 32'h55, 32'h4, 8'hE8, 0));
    vecs.push_back(mk("use_stall", 1, 5, 6, 7, 1, 32'h1, 32'h2, 32'h0, 8'h84, 0, 1, 0, 1, 5, 5, 32'h100, 32'h55, 32'h4, 8'h00, 1));
    vecs.push_back(mk("use_capt", 1, 5, 6, 7, 1, 32'h1, 32'h2, 32'h0, 8'h84, 0, 0, 1, 5, 6, 7, 32'h1, 32'h2, 32'h0, 8'h84, 1));
    vecs.push_back(mk("lw_r0", 1, 2, 0, 0, 0, 32'h7, 32'h8, 32'h8, 8'hE8, 0, 0, 1, 2, 0, 0, 32'h7, 32'h8, 32'h8, 8'hE8, 1));
    vecs.push_back(mk("read_r0", 1, 0, 0, 9, 1, 32'h0, 32'h0, 32'h0, 8'h84, 0, 0, 1, 0, 0, 9, 32'h0, 32'h0, 32'h0, 8'h84, 1));
    vecs.push_back(mk("lw_r5b", 1, 3, 5, 0, 0, 32'h30, 32'h31, 32'h10, 8'hE8, 0, 0, 1, 3, 5, 5, 32'h30, 32'h31, 32'h10, 8'hE8, 1));
    vecs.push_back(mk("flush_haz", 1, 4, 5, 6, 1, 32'h44, 32'h45, 32'h0, 8'h84, 1, 0, 0, 3, 5, 5, 32'h30, 32'h31, 32'h10, 8'h00, 2));
    vecs.push_back(mk("idle", 0, 4, 5, 6, 1, 32'h44, 32'h45, 32'h0, 8'h84, 0, 0, 0, 3, 5, 5, 32'h30, 32'h31, 32'h10, 8'h00, 2));
    vecs.push_back(mk("lw_r8", 1, 1, 8, 0, 0, 32'h1, 32'h2, 32'h3, 8'hE8, 0, 0, 1, 1, 8, 8, 32'h1, 32'h2, 32'h3, 8'hE8, 2));
    vecs.push_back(mk("no_rt_use", 1, 9, 8, 0, 0, 32'h9, 32'hDEAD, 32'h20, 8'h88, 0, 0, 1, 9, 8, 8, 32'h9, 32'hDEAD, 32'h20, 8'h88, 2));
    v = mk("wb_bypass", 1, 7, 1, 2, 1, 32'h0, 32'h5, 32'h0, 8'h84, 0, 0, 1, 7, 1, 2, BYP_A, 32'h5, 32'h0, 8'h84, 2);
    v.wwe = 1'b1; v.wreg = 5'd7; v.wdata = 32'h0000ABCD;
    vecs.push_back(v);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.stall", 64'(stall), 64'd0);
    check_ex("reset", 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd0);
    @(negedge clk);
    init_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].uses_rt,
            vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].ctrl, vecs[i].fl);
      wb_we = vecs[i].wwe; wb_reg = vecs[i].wreg; wb_data = vecs[i].wdata;
      #1;
      check({vecs[i].name, ".stall"}, 64'(stall), 64'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check_ex(vecs[i].name, vecs[i].e_valid, vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_dst,
               vecs[i].e_a, vecs[i].e_b, vecs[i].e_imm, vecs[i].e_ctrl, vecs[i].e_cnt);
      @(negedge clk);
    end
    wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;

    // Reset asserted mid-cycle while a load-use stall is active
    drive(1, 1, 5, 0, 0, 32'h1, 32'h2, 32'h3, 8'hE8, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 5, 6, 7, 1, 32'h1, 32'h2, 32'h0, 8'h84, 0);
    #1;
    check("rst_mid.stall_before", 64'(stall), 64'd1);
    check("rst_mid.valid_before", 64'(ex_valid), 64'd1);
    #1;
    init_n = 1'b0;
    #1;
    check("rst_mid.stall", 64'(stall), 64'd0);
    check_ex("rst_mid", 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 1);
    init_n = 1'b1;

    // Bubble counter saturation: 65535 flush bubbles reach all-ones, one more must not wrap
    repeat (65535) @(posedge clk);
    #1;
    check("sat.reach", 64'(bubble_cnt), 64'hFFFF);
    @(posedge clk);
    #1;
    check("sat.hold", 64'(bubble_cnt), 64'hFFFF);
    check("sat.valid", 64'(ex_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
